fp_divider: RTL and testbench

// Iterative single-precision floating-point divider, z = x / y, in the RISC5 FP format:

---
 rtl/fp_divider.sv | 127 ++++++++++++
 tb/tb_fp_divider.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/fp_divider.sv
// Iterative single-precision divider, one restoring step per clock.
// Truncated mantissa; zero, overflow and underflow mapped to fixed codes.
module fp_divider #(
  parameter int EBIAS = 127,
  parameter int QBITS = 25
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic [31:0] x,
  input  logic [31:0] y,
  output logic        stall,
  output logic [31:0] z
);

  typedef enum logic [1:0] {IDLE, DIV, NORM, DONE} state_t;

  state_t      state_q, state_d;
  logic [4:0]  count_q, count_d;
  logic [24:0] r_q, r_d;
  logic [23:0] d_q, d_d;
  logic [24:0] q_q, q_d;
  logic        s_q, s_d;
  logic [7:0]  xe_q, xe_d;
  logic [7:0]  ye_q, ye_d;
  logic [31:0] z_q, z_d;

  logic [24:0] diff;
  logic [9:0]  e;
  logic [22:0] m;
  logic        e_le0;
  logic        e_ge255;

  assign stall = run & (state_q != DONE);
  assign z     = z_q;

  always_comb begin
    diff    = r_q - {1'b0, d_q};
    // 10-bit two's complement exponent; a missing leading one costs 1
    e       = {2'b0, xe_q} - {2'b0, ye_q} + 10'(EBIAS)
            - {9'b0, ~q_q[24]};
    m       = q_q[24] ? q_q[23:1] : q_q[22:0];
    e_le0   = e[9] | (e == 10'd0);
    e_ge255 = ~e[9] & (e >= 10'd255);

    state_d = state_q;
    count_d = count_q;
    r_d     = r_q;
    d_d     = d_q;
    q_d     = q_q;
    s_d     = s_q;
    xe_d    = xe_q;
    ye_d    = ye_q;
    z_d     = z_q;

    unique case (state_q)
      IDLE: begin
        if (run) begin
          s_d     = x[31] ^ y[31];
          xe_d    = x[30:23];
          ye_d    = y[30:23];
          r_d     = {2'b01, x[22:0]};
          d_d     = {1'b1, y[22:0]};
          q_d     = '0;
          count_d = '0;
          state_d = DIV;
        end
      end
      DIV: begin
        if (!run) begin
          state_d = IDLE;
        end else begin
          if (r_q >= {1'b0, d_q}) begin
            r_d = {diff[23:0], 1'b0};
            q_d = {q_q[23:0], 1'b1};
          end else begin
            r_d = {r_q[23:0], 1'b0};
            q_d = {q_q[23:0], 1'b0};
          end
          count_d = count_q + 5'd1;
          if (count_q == 5'(QBITS - 1)) state_d = NORM;
        end
      end
      NORM: begin
        if (!run) begin
          state_d = IDLE;
        end else begin
          if (ye_q == 8'd0)      z_d = {s_q, 8'hFF, 23'b0};
          else if (xe_q == 8'd0) z_d = '0;
          else if (e_le0)        z_d = '0;
          else if (e_ge255)      z_d = {s_q, 8'hFF, 23'b0};
          else                   z_d = {s_q, e[7:0], m};
          state_d = DONE;
        end
      end
      DONE: begin
        if (!run) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      count_q <= '0;
      r_q     <= '0;
      d_q     <= '0;
      q_q     <= '0;
      s_q     <= 1'b0;
      xe_q    <= '0;
      ye_q    <= '0;
      z_q     <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      r_q     <= r_d;
      d_q     <= d_d;
      q_q     <= q_d;
      s_q     <= s_d;
      xe_q    <= xe_d;
      ye_q    <= ye_d;
      z_q     <= z_d;
    end
  end

endmodule

// File: tb/tb_fp_divider.sv
// Directed and random checks of fp_divider against an arithmetic model.
// Quotient reference is exact integer division of the mantissas.
module tb_fp_divider;

  logic        clk;
  logic        rst;
  logic        run;
  logic [31:0] x;
  logic [31:0] y;
  logic        stall;
  logic [31:0] z;

  int checks   = 0;
  int failures = 0;

  fp_divider dut (
    .clk   (clk),
    .rst   (rst),
    .run   (run),
    .x     (x),
    .y     (y),
    .stall (stall),
    .z     (z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ref_div(input logic [31:0] a,
                                          input logic [31:0] b);
    logic        s;
    longint      ea, eb, e, q, m;
    s  = a[31] ^ b[31];
    ea = longint'(a[30:23]);
    eb = longint'(b[30:23]);
    if (eb == 0) return {s, 8'hFF, 23'b0};
    if (ea == 0) return 32'h0;
    q = ((64'h800000 + longint'(a[22:0])) * 64'h1000000)
      / (64'h800000 + longint'(b[22:0]));
    e = ea - eb + 127;
    if (q >= 64'h1000000) begin
      m = (q / 2) % 64'h800000;
    end else begin
      m = q % 64'h800000;
      e = e - 1;
    end
    if (e <= 0)   return 32'h0;
    if (e >= 255) return {s, 8'hFF, 23'b0};
    return {s, 8'(e), 23'(m)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(output int n);
    n = 0;
    #1;
    while (stall && n < 100) begin
      n++;
      @(negedge clk);
      #1;
    end
  endtask

  task automatic do_div(input logic [31:0] a, input logic [31:0] b,
                        input string tag);
    int n;
    logic [31:0] exp;
    exp = ref_div(a, b);
    @(negedge clk);
    x   = a;
    y   = b;
    run = 1'b1;
    wait_done(n);
    chk({tag, "_lat"}, 32'(n), 32'd27);
    chk(tag, z, exp);
    @(negedge clk);
    run = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int n;
    logic [31:0] held;
    logic [31:0] a, b;
    rst = 1'b0;
    run = 1'b0;
    x   = '0;
    y   = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_z", z, 32'h0);
    chk("rst_stall_idle", {31'b0, stall}, 32'h0);
    run = 1'b1;
    #1;
    chk("rst_stall_run", {31'b0, stall}, 32'h1);
    run = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    do_div(32'h3F800000, 32'h3F800000, "one_one");
    do_div(32'h3F800000, 32'h40400000, "one_three");
    do_div(32'h40C00000, 32'hC0000000, "six_m2");
    do_div(32'h00000000, 32'h40A00000, "x_zero");
    do_div(32'h3F800000, 32'h00000000, "div_zero");
    do_div(32'h0D800000, 32'h71800000, "underflow");
    do_div(32'h71800000, 32'h0D800000, "overflow");

    // run held across DONE must neither restart nor disturb z
    @(negedge clk);
    x   = 32'h40C00000;
    y   = 32'h40400000;
    run = 1'b1;
    wait_done(n);
    chk("hold_lat", 32'(n), 32'd27);
    held = ref_div(32'h40C00000, 32'h40400000);
    chk("hold_z0", z, held);
    x = 32'h3F800000;
    repeat (3) @(negedge clk);
    #1;
    chk("hold_stall", {31'b0, stall}, 32'h0);
    chk("hold_z", z, held);
    run = 1'b0;
    @(negedge clk);

    // drop run mid-divide: back to idle, z untouched
    x   = 32'h3F800000;
    y   = 32'h40400000;
    run = 1'b1;
    repeat (6) @(negedge clk);
    run = 1'b0;
    repeat (30) @(negedge clk);
    #1;
    chk("abort_stall", {31'b0, stall}, 32'h0);
    chk("abort_z", z, held);
    do_div(32'h3F800000, 32'h40400000, "after_abort");

    // async reset during DIV, count=10
    @(negedge clk);
    x   = 32'h40C00000;
    y   = 32'hC0000000;
    run = 1'b1;
    repeat (11) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_z", z, 32'h0);
    chk("arst_stall", {31'b0, stall}, 32'h1);
    @(negedge clk);
    run = 1'b0;
    #1;
    chk("arst_stall_lo", {31'b0, stall}, 32'h0);
    rst = 1'b1;
    do_div(32'h3F800000, 32'h40400000, "rerun");

    for (int i = 0; i < 24; i++) begin
      a = $urandom;
      b = $urandom;
      if (i % 3 != 0) begin
        a[30:23] = 8'($urandom_range(100, 155));
        b[30:23] = 8'($urandom_range(100, 155));
      end
      do_div(a, b, $sformatf("rnd%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
